// File: rtl/counter_display_pkg.sv
// counter_display_pkg: seven-segment patterns, digit limits and load clamp
// shared by the counter_display top and its digit_cell instances.
package counter_display_pkg;

    // Segment patterns, bit 6 = a ... bit 0 = g, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Largest value a single digit reaches before wrapping.
    function automatic logic [3:0] digit_max(input bit decimal);
        return decimal ? 4'd9 : 4'd15;
    endfunction

    // Load values above the digit range are pinned to the digit maximum.
    function automatic logic [3:0] clamp_digit(input logic [3:0] v, input bit decimal);
        return (decimal && (v > 4'd9)) ? 4'd9 : v;
    endfunction

    // Per-digit seven-segment decode (A..F shown as A, b, C, d, E, F).
    function automatic logic [6:0] sevenseg(input logic [3:0] d);
        case (d)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/counter_display_if.sv
// counter_display_if: control inputs and display outputs of counter_display.
interface counter_display_if #(
    parameter int N_DIGITS = 2
);
    logic                    en;
    logic                    up;
    logic                    load;
    logic [4*N_DIGITS-1:0]   load_val;
    logic [4*N_DIGITS-1:0]   count;
    logic [7*N_DIGITS-1:0]   seg;
    logic                    tc;

    modport master (output en, up, load, load_val, input count, seg, tc);
    modport slave  (input en, up, load, load_val, output count, seg, tc);
endinterface

// File: rtl/counter_display_digit_cell.sv
// digit_cell: one 4-bit counter digit with load/clamp and a carry/borrow
// chain. carry_in means "this digit steps this cycle"; carry_out is raised
// when it steps from its limit, so the next digit steps too.
module digit_cell
    import counter_display_pkg::*;
#(
    parameter bit DECIMAL = 1'b1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       up,
    input  logic       carry_in,
    output logic       carry_out,
    output logic [3:0] value
);
    logic [3:0] max_v;
    logic       at_limit;

    assign max_v     = digit_max(DECIMAL);
    assign at_limit  = up ? (value == max_v) : (value == 4'd0);
    assign carry_out = carry_in & at_limit;

    // Digit register: load beats stepping; stepping wraps at the limit.
    always_ff @(posedge clk or negedge clr) begin
        // NOTE: non-blocking so every digit sees the pre-edge carry chain.
        if (!clr) begin
            value <= 4'd0;
        end else if (load) begin
            value <= clamp_digit(load_val, DECIMAL);
        end else if (carry_in) begin
            if (at_limit) value <= up ? 4'd0 : max_v;
            else          value <= up ? value + 4'd1 : value - 4'd1;
        end
    end
endmodule

// File: rtl/counter_display.sv
// counter_display: N-digit BCD/hex up/down counter with tick prescaler,
// terminal-count pulse and direct seven-segment drive.
// Build option: COUNTER_DISPLAY_BLANK_EN enables leading-zero blanking.
module counter_display
    import counter_display_pkg::*;
#(
    parameter int N_DIGITS = 2,
    parameter bit DECIMAL  = 1'b1,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              clr,
    counter_display_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]         pre;
    logic                  tick;
    logic                  step;
    logic                  tc_q;
    logic [N_DIGITS:0]     carry;
    logic [3:0]            digit [N_DIGITS];
    logic [N_DIGITS-1:0]   blank;
    logic                  zero_above;
    logic [4*N_DIGITS-1:0] count_w;
    logic [7*N_DIGITS-1:0] seg_w;

    assign tick = (pre == PW'(PRESCALE - 1));

    // Free-running prescaler; load does not disturb it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)      pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + PW'(1);
    end

    // A load consumes the tick, so only an unloaded enabled tick counts.
    assign step     = tick & bus.en & ~bus.load;
    assign carry[0] = step;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        digit_cell #(.DECIMAL(DECIMAL)) u_digit (
            .clk       (clk),
            .clr       (clr),
            .load      (bus.load),
            .load_val  (bus.load_val[4*g +: 4]),
            .up        (bus.up),
            .carry_in  (carry[g]),
            .carry_out (carry[g+1]),
            .value     (digit[g])
        );
    end

    // Terminal count: carry out of the top digit means the whole counter wrapped.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) tc_q <= 1'b0;
        else      tc_q <= carry[N_DIGITS];
    end

    // Pack digits, work out leading-zero blanking and decode segments.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch.
        count_w    = '0;
        seg_w      = '0;
        blank      = '0;
        zero_above = 1'b1;
`ifdef COUNTER_DISPLAY_BLANK_EN
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (digit[k] == 4'd0);
            blank[k]   = zero_above && (k != 0);
        end
`endif
        for (int k = 0; k < N_DIGITS; k++) begin
            count_w[4*k +: 4] = digit[k];
            seg_w[7*k +: 7]   = blank[k] ? SEG_BLANK : sevenseg(digit[k]);
        end
    end

    assign bus.count = count_w;
    assign bus.seg   = seg_w;
    assign bus.tc    = tc_q;
endmodule

// File: tb/tb_counter_display.sv
// tb_counter_display: two instances (2-digit decimal with PRESCALE=1, and
// 2-digit hex with PRESCALE=4) share one random stimulus stream. Expected
// outputs come from an integer model (value mod radix^2) and are queued;
// a monitor pops one entry per clock and compares.
module tb_counter_display;

    logic       clk = 1'b0;
    logic       clr;
    logic       en, up, load;
    logic [7:0] load_val;

    always #5 clk = ~clk;

    counter_display_if #(.N_DIGITS(2)) if_a ();
    counter_display_if #(.N_DIGITS(2)) if_b ();

    assign if_a.en = en;  assign if_a.up = up;  assign if_a.load = load;  assign if_a.load_val = load_val;
    assign if_b.en = en;  assign if_b.up = up;  assign if_b.load = load;  assign if_b.load_val = load_val;

    counter_display #(.N_DIGITS(2), .DECIMAL(1'b1), .PRESCALE(1)) dut_a (
        .clk (clk), .clr (clr), .bus (if_a)
    );
    counter_display #(.N_DIGITS(2), .DECIMAL(1'b0), .PRESCALE(4)) dut_b (
        .clk (clk), .clr (clr), .bus (if_b)
    );

    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct {
        logic [7:0]  count_a;
        logic [13:0] seg_a;
        logic        tc_a;
        logic [7:0]  count_b;
        logic [13:0] seg_b;
        logic        tc_b;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_x;
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          running  = 1'b0;
    int          cyc;
    int unsigned va, vb;
    bit          ta, tb_tc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] to_digits(input int unsigned v, input int unsigned r);
        logic [7:0] d;
        d[3:0] = 4'(v % r);
        d[7:4] = 4'((v / r) % r);
        return d;
    endfunction

    function automatic logic [13:0] to_seg(input int unsigned v, input int unsigned r);
        logic [13:0] s;
        s[6:0]  = seg_tab[v % r];
        s[13:7] = seg_tab[(v / r) % r];
`ifdef COUNTER_DISPLAY_BLANK_EN
        if (v / r == 0) s[13:7] = 7'b0000000;
`endif
        return s;
    endfunction

    function automatic int unsigned from_load(input logic [7:0] lv, input int unsigned r);
        int unsigned lo = lv[3:0];
        int unsigned hi = lv[7:4];
        if (r == 10) begin
            if (lo > 9) lo = 9;
            if (hi > 9) hi = 9;
        end
        return hi * r + lo;
    endfunction

    // Whole-counter behaviour: value is an integer modulo radix^2.
    task automatic model_step(inout int unsigned v, output bit t, input int unsigned r, input int p);
        int unsigned top = r * r - 1;
        t = 1'b0;
        if (load) begin
            v = from_load(load_val, r);
        end else if (en && (cyc % p == p - 1)) begin
            if (up) begin
                t = (v == top);
                v = (v == top) ? 0 : v + 1;
            end else begin
                t = (v == 0);
                v = (v == 0) ? top : v - 1;
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs.
    task automatic apply(input bit l, input logic [7:0] lv, input bit e, input bit u);
        exp_t x;
        load = l; load_val = lv; en = e; up = u;
        model_step(va, ta, 10, 1);
        model_step(vb, tb_tc, 16, 4);
        x.count_a = to_digits(va, 10);
        x.seg_a   = to_seg(va, 10);
        x.tc_a    = ta;
        x.count_b = to_digits(vb, 16);
        x.seg_b   = to_seg(vb, 16);
        x.tc_b    = tb_tc;
        sb.push_back(x);
        cyc++;
        @(negedge clk);
    endtask

    // Monitor: one output sample per clock, compared to the queue head.
    always begin
        @(posedge clk);
        #1;
        if (running) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                mon_x = sb.pop_front();
                check("count_a", if_a.count, mon_x.count_a);
                check("seg_a",   if_a.seg,   mon_x.seg_a);
                check("tc_a",    if_a.tc,    mon_x.tc_a);
                check("count_b", if_b.count, mon_x.count_b);
                check("seg_b",   if_b.seg,   mon_x.seg_b);
                check("tc_b",    if_b.tc,    mon_x.tc_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r_up;
        logic [7:0]  lv;
        clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = 8'h00;
        va = 0; vb = 0; ta = 0; tb_tc = 0; cyc = 0;
        repeat (2) @(negedge clk);

        check("rst_count_a", if_a.count, 8'h00);
        check("rst_tc_a",    if_a.tc,    1'b0);
        check("rst_seg_a",   if_a.seg,   to_seg(0, 10));
        check("rst_count_b", if_b.count, 8'h00);
        check("rst_seg_b",   if_b.seg,   to_seg(0, 16));

        clr = 1'b1;
        running = 1'b1;

        // Decimal up wrap 98 -> 99 -> 00 (tc) -> 01.
        apply(1'b1, 8'h98, 1'b0, 1'b1);
        repeat (8) apply(1'b0, 8'h00, 1'b1, 1'b1);

        // Down wrap through zero for both radices.
        apply(1'b1, 8'h01, 1'b0, 1'b0);
        repeat (12) apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Load beats a same-cycle tick; decimal clamps C5 to 95.
        apply(1'b1, 8'hC5, 1'b1, 1'b1);
        repeat (2) apply(1'b0, 8'h00, 1'b0, 1'b1);

        // Leading-zero display cases.
        apply(1'b1, 8'h05, 1'b0, 1'b1);
        apply(1'b1, 8'h50, 1'b0, 1'b1);
        apply(1'b1, 8'h00, 1'b0, 1'b1);

        // en low across several ticks holds the count.
        repeat (8) apply(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (9) apply(1'b0, 8'h00, 1'b1, 1'b1);

        // Random traffic biased toward wrap boundaries.
        r_up = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 19) == 0) r_up = ~r_up;
            case ($urandom_range(0, 3))
                0:       lv = 8'h99;
                1:       lv = 8'h00;
                2:       lv = 8'hFF;
                default: lv = 8'($urandom);
            endcase
            apply($urandom_range(0, 9) == 0, lv, $urandom_range(0, 3) != 0, r_up);
        end

        // Mid-count asynchronous reset: load 37, then clear between edges.
        apply(1'b1, 8'h37, 1'b0, 1'b1);
        running = 1'b0;
        load = 1'b0; en = 1'b1;
        #3 clr = 1'b0;
        #1;
        check("async_count_a", if_a.count, 8'h00);
        check("async_tc_a",    if_a.tc,    1'b0);
        check("async_seg0_a",  if_a.seg[6:0], 7'b1111110);
        check("async_count_b", if_b.count, 8'h00);
        check("async_tc_b",    if_b.tc,    1'b0);
        repeat (3) @(negedge clk);
        check("hold_rst_count_a", if_a.count, 8'h00);
        check("hold_rst_tc_a",    if_a.tc,    1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
